transmite_bcd_ascii_n_digitos: RTL and testbench

Transmits an N-digit packed-BCD value as a string of ASCII characters over one 8O1 serial line: most significant digit first, with optional leading-zero suppression and an optional terminator character. It sits between the measurement/display datapath and the UART pin. It replaces per-digit, externally sequenced transmission with a single `partida`/`pronto` handshake per message.

---
 rtl/transmite_bcd_ascii_n_digitos_pkg.sv | 27 ++
 rtl/transmite_bcd_ascii_n_digitos_tx_serial_8O1.sv | 66 ++++++
 rtl/transmite_bcd_ascii_n_digitos.sv | 103 ++++++++++
 tb/tb_transmite_bcd_ascii_n_digitos.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmite_bcd_ascii_n_digitos_pkg.sv
// Shared constants for the BCD-to-ASCII serial sender: character codes,
// FSM state codes seen on db_estado, and the digit-to-character mapping.
package transmite_bcd_ascii_n_digitos_pkg;

    localparam logic [7:0] ASCII_ZERO         = 8'h30;
    localparam logic [7:0] ASCII_INTERROGACAO = 8'h3F;
    localparam logic [7:0] ASCII_LF           = 8'h0A;

    localparam logic [3:0] OCIOSO      = 4'd0;
    localparam logic [3:0] REGISTRA    = 4'd1;
    localparam logic [3:0] AVALIA      = 4'd2;
    localparam logic [3:0] TRANSMITE   = 4'd3;
    localparam logic [3:0] ESPERA      = 4'd4;
    localparam logic [3:0] PROXIMO     = 4'd5;
    localparam logic [3:0] TERM        = 4'd6;
    localparam logic [3:0] ESPERA_TERM = 4'd7;
    localparam logic [3:0] FINAL       = 4'd8;

    // Invalid BCD codes (A-F) are shown as '?' rather than as punctuation.
    function automatic logic [7:0] bcd_para_ascii(input logic [3:0] digito);
        if (digito <= 4'd9)
            return ASCII_ZERO | {4'b0000, digito};
        else
            return ASCII_INTERROGACAO;
    endfunction

endpackage

// File: rtl/transmite_bcd_ascii_n_digitos_tx_serial_8O1.sv
// 8O1 serial transmitter: start bit, 8 data bits LSB first, odd parity,
// one stop bit. Pulses pronto for one clock after the stop bit ends.
module tx_serial_8O1 #(
    parameter int FREQ_CLOCK = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto
);

    localparam int CICLOS_BIT = FREQ_CLOCK / BAUD_RATE;
    localparam int W_TICK     = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam logic [W_TICK-1:0] TICK_FIM = W_TICK'(CICLOS_BIT - 1);

    logic              r_ativo;
    logic              r_saida;
    logic              r_pronto;
    logic [9:0]        r_dados;
    logic [W_TICK-1:0] r_tick;
    logic [3:0]        r_nbit;

    // NOTE: sequential state is written with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ativo  <= 1'b0;
            r_saida  <= 1'b1;
            r_pronto <= 1'b0;
            r_dados  <= '1;
            r_tick   <= '0;
            r_nbit   <= '0;
        end else begin
            r_pronto <= 1'b0;
            if (!r_ativo) begin
                if (partida) begin
                    r_ativo <= 1'b1;
                    r_saida <= 1'b0;
                    r_dados <= {1'b1, ~^dados_ascii, dados_ascii};
                    r_tick  <= '0;
                    r_nbit  <= '0;
                end
            end else if (r_tick != TICK_FIM) begin
                r_tick <= r_tick + W_TICK'(1);
            end else begin
                r_tick <= '0;
                // Bit 10 is the stop bit; the line is already high when it ends.
                if (r_nbit == 4'd10) begin
                    r_ativo  <= 1'b0;
                    r_pronto <= 1'b1;
                    r_saida  <= 1'b1;
                end else begin
                    r_nbit  <= r_nbit + 4'd1;
                    r_saida <= r_dados[0];
                    r_dados <= {1'b1, r_dados[9:1]};
                end
            end
        end
    end

    assign saida_serial = r_saida;
    assign pronto       = r_pronto;

endmodule

// File: rtl/transmite_bcd_ascii_n_digitos.sv
// Sends an N-digit packed BCD value as ASCII over an 8O1 line, MSD first,
// with optional leading-zero suppression and terminator; one partida/pronto per message.
module transmite_bcd_ascii_n_digitos
    import transmite_bcd_ascii_n_digitos_pkg::*;
#(
    parameter int         N_DIGITOS        = 3,
    parameter int         BAUD_RATE        = 115200,
    parameter int         FREQ_CLOCK       = 50_000_000,
    parameter int         SUPRIME_ZEROS    = 1,
    parameter int         ENVIA_TERMINADOR = 1,
    parameter logic [7:0] TERMINADOR       = ASCII_LF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   partida,
    input  logic [4*N_DIGITOS-1:0] bcd,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   saida_serial,
    output logic [3:0]             db_estado
);

    localparam int W_IDX = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

    logic [3:0]             r_estado;
    logic [3:0]             w_prox;
    logic [4*N_DIGITOS-1:0] r_bcd;
    logic [W_IDX-1:0]       r_indice;
    logic                   r_suprimindo;
    logic [3:0]             w_digito;
    logic                   w_pula;
    logic                   w_tx_partida;
    logic                   w_tx_pronto;
    logic [7:0]             w_caractere;

    assign w_digito     = 4'(r_bcd >> {r_indice, 2'b00});
    // The last digit is never skipped, so an all-zero value still sends "0".
    assign w_pula       = r_suprimindo && (w_digito == 4'd0) && (r_indice != '0);
    assign w_tx_partida = (r_estado == TRANSMITE) || (r_estado == TERM);
    assign w_caractere  = (r_estado == TERM) ? TERMINADOR : bcd_para_ascii(w_digito);

    always_comb begin
        // NOTE: defaulting the next state first keeps this block free of inferred latches.
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:      if (partida) w_prox = REGISTRA;
            REGISTRA:    w_prox = AVALIA;
            AVALIA:      w_prox = w_pula ? PROXIMO : TRANSMITE;
            TRANSMITE:   w_prox = ESPERA;
            ESPERA:      if (w_tx_pronto) w_prox = PROXIMO;
            PROXIMO: begin
                if (r_indice != '0)
                    w_prox = AVALIA;
                else if (ENVIA_TERMINADOR != 0)
                    w_prox = TERM;
                else
                    w_prox = FINAL;
            end
            TERM:        w_prox = ESPERA_TERM;
            ESPERA_TERM: if (w_tx_pronto) w_prox = FINAL;
            FINAL:       w_prox = OCIOSO;
            default:     w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado     <= OCIOSO;
            r_bcd        <= '0;
            r_indice     <= '0;
            r_suprimindo <= 1'b0;
        end else begin
            r_estado <= w_prox;
            case (r_estado)
                REGISTRA: begin
                    r_bcd        <= bcd;
                    r_indice     <= W_IDX'(N_DIGITOS - 1);
                    r_suprimindo <= (SUPRIME_ZEROS != 0);
                end
                AVALIA:  if (!w_pula) r_suprimindo <= 1'b0;
                PROXIMO: if (r_indice != '0) r_indice <= r_indice - W_IDX'(1);
                default: ;
            endcase
        end
    end

    tx_serial_8O1 #(
        .FREQ_CLOCK (FREQ_CLOCK),
        .BAUD_RATE  (BAUD_RATE)
    ) u_tx (
        .clock        (clock),
        .reset        (reset),
        .partida      (w_tx_partida),
        .dados_ascii  (w_caractere),
        .saida_serial (saida_serial),
        .pronto       (w_tx_pronto)
    );

    assign ocupado   = (r_estado != OCIOSO) && (r_estado != FINAL);
    assign pronto    = (r_estado == FINAL);
    assign db_estado = r_estado;

endmodule

// File: tb/tb_transmite_bcd_ascii_n_digitos.sv
// Bench for transmite_bcd_ascii_n_digitos: three configurations, a line decoder
// and a string-level model of the expected characters for each message.
module tb_transmite_bcd_ascii_n_digitos;
    import transmite_bcd_ascii_n_digitos_pkg::*;

    localparam int FREQ = 50_000_000;
    localparam int BAUD = 5_000_000;
    localparam int BIT  = FREQ / BAUD;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  part;
    logic [11:0] bcd_a, bcd_b;
    logic [3:0]  bcd_c;
    logic [2:0]  ocup, prn, ser;
    logic [3:0]  dbe [3];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Line decoder and scoreboard state, one slot per DUT.
    bit         rx_busy [3];
    int         rx_cnt [3];
    logic [10:0] rx_bits [3];
    int         rx_done_cyc [3];
    int         pronto_cnt [3];
    int         p0_cnt [3];
    logic [7:0] rx_log [3][$];
    logic       rx_par [3][$];
    logic [7:0] exp_q [3][$];
    logic [7:0] mdl_q [$];

    always #5 clock = ~clock;

    // a: defaults; b: no suppression; c: one digit, no terminator.
    transmite_bcd_ascii_n_digitos #(.N_DIGITOS(3), .BAUD_RATE(BAUD), .FREQ_CLOCK(FREQ),
        .SUPRIME_ZEROS(1), .ENVIA_TERMINADOR(1), .TERMINADOR(8'h0A)) dut_a (
        .clock(clock), .reset(reset), .partida(part[0]), .bcd(bcd_a), .ocupado(ocup[0]),
        .pronto(prn[0]), .saida_serial(ser[0]), .db_estado(dbe[0]));

    transmite_bcd_ascii_n_digitos #(.N_DIGITOS(3), .BAUD_RATE(BAUD), .FREQ_CLOCK(FREQ),
        .SUPRIME_ZEROS(0), .ENVIA_TERMINADOR(1), .TERMINADOR(8'h0A)) dut_b (
        .clock(clock), .reset(reset), .partida(part[1]), .bcd(bcd_b), .ocupado(ocup[1]),
        .pronto(prn[1]), .saida_serial(ser[1]), .db_estado(dbe[1]));

    transmite_bcd_ascii_n_digitos #(.N_DIGITOS(1), .BAUD_RATE(BAUD), .FREQ_CLOCK(FREQ),
        .SUPRIME_ZEROS(1), .ENVIA_TERMINADOR(0), .TERMINADOR(8'h0A)) dut_c (
        .clock(clock), .reset(reset), .partida(part[2]), .bcd(bcd_c), .ocupado(ocup[2]),
        .pronto(prn[2]), .saida_serial(ser[2]), .db_estado(dbe[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int cfg_ndig(input int g);
        return (g == 2) ? 1 : 3;
    endfunction
    function automatic bit cfg_sup(input int g);
        return (g != 1);
    endfunction
    function automatic bit cfg_term(input int g);
        return (g != 2);
    endfunction

    // Expected message as a character string: digits MSD first, leading zeros
    // dropped (keeping the last digit) when suppressing, then the terminator.
    function automatic void model(input int g, input logic [11:0] v);
        bit         started;
        logic [3:0] d;
        mdl_q.delete();
        started = !cfg_sup(g);
        for (int i = cfg_ndig(g) - 1; i >= 0; i--) begin
            d = 4'(v >> (4 * i));
            if (!started && d == 4'd0 && i != 0) continue;
            started = 1'b1;
            mdl_q.push_back((d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F);
        end
        if (cfg_term(g)) mdl_q.push_back(8'h0A);
    endfunction

    // Single compare process: decodes every line, checks frames against the
    // model queue and pronto/ocupado/idle-line rules on every cycle.
    always @(negedge clock) begin
        int         k;
        int         delta;
        logic [7:0] b;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            if (reset) begin
                rx_busy[g] = 1'b0;
                continue;
            end
            if (!ocup[g]) check("line_idle", ser[g], 1'b1);
            if (prn[g]) begin
                pronto_cnt[g]++;
                delta = cyc - rx_done_cyc[g];
                check("ocupado_during_pronto", ocup[g], 1'b0);
                check("pronto_all_sent", exp_q[g].size(), 0);
                check("pronto_after_stop", (delta >= BIT - BIT/2) && (delta <= BIT - BIT/2 + 4), 1'b1);
            end
            if (!rx_busy[g]) begin
                if (ser[g] == 1'b0) begin
                    rx_busy[g] = 1'b1;
                    rx_cnt[g]  = 0;
                end
            end else begin
                rx_cnt[g]++;
            end
            if (rx_busy[g] && (rx_cnt[g] % BIT) == BIT/2) begin
                k = rx_cnt[g] / BIT;
                rx_bits[g][k] = ser[g];
                if (k == 10) begin
                    b = rx_bits[g][8:1];
                    check("start_bit", rx_bits[g][0], 1'b0);
                    check("stop_bit", rx_bits[g][10], 1'b1);
                    check("odd_parity", ^rx_bits[g][9:1], 1'b1);
                    rx_log[g].push_back(b);
                    rx_par[g].push_back(rx_bits[g][9]);
                    check("frame_expected", exp_q[g].size() > 0, 1'b1);
                    if (exp_q[g].size() > 0) check("frame_byte", b, exp_q[g].pop_front());
                    rx_done_cyc[g] = cyc;
                    rx_busy[g] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // lit holds the hand-computed characters, first character in the upper byte.
    task automatic start_msg(input int g, input logic [11:0] v, input logic [31:0] lit, input int nlit);
        logic [7:0] e;
        model(g, v);
        check("model_len", mdl_q.size(), nlit);
        for (int i = 0; i < nlit && i < mdl_q.size(); i++) begin
            e = lit[8*(nlit-1-i) +: 8];
            check("model_char", mdl_q[i], e);
        end
        exp_q[g] = mdl_q;
        rx_log[g].delete();
        rx_par[g].delete();
        p0_cnt[g] = pronto_cnt[g];
        case (g)
            0:       bcd_a = v;
            1:       bcd_b = v;
            default: bcd_c = v[3:0];
        endcase
        part[g] = 1'b1;
        tick();
        part[g] = 1'b0;
        check("estado_registra", dbe[g], REGISTRA);
        check("ocupado_inicio", ocup[g], 1'b1);
        tick();
        check("estado_avalia", dbe[g], AVALIA);
    endtask

    task automatic finish_msg(input int g, input int nlit);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (pronto_cnt[g] != p0_cnt[g]) begin
                ok = 1'b1;
                break;
            end
        end
        check("pronto_timeout", ok, 1'b1);
        repeat (30) tick();
        check("pronto_count", pronto_cnt[g] - p0_cnt[g], 1);
        check("frames_received", rx_log[g].size(), nlit);
        check("frames_pending", exp_q[g].size(), 0);
        check("idle_after", ocup[g], 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b1;
        part  = '0;
        bcd_a = '0;
        bcd_b = '0;
        bcd_c = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int g = 0; g < 3; g++) begin
            check("reset_ocupado", ocup[g], 1'b0);
            check("reset_pronto", prn[g], 1'b0);
            check("reset_saida", ser[g], 1'b1);
            check("reset_estado", dbe[g], OCIOSO);
        end

        start_msg(0, 12'h042, 32'h0034320A, 3);
        finish_msg(0, 3);
        check("parity_0x34", (rx_par[0].size() > 0) ? rx_par[0][0] : 1'bx, 1'b0);
        check("first_char_0x34", (rx_log[0].size() > 0) ? rx_log[0][0] : 8'hxx, 8'h34);

        start_msg(0, 12'h000, 32'h0000300A, 2);
        finish_msg(0, 2);

        start_msg(1, 12'h007, 32'h3030370A, 4);
        finish_msg(1, 4);

        start_msg(0, 12'h1A5, 32'h313F350A, 4);
        finish_msg(0, 4);

        start_msg(0, 12'h0B0, 32'h003F300A, 3);
        finish_msg(0, 3);

        // bcd changed and partida pulsed while the second character is on the line.
        start_msg(0, 12'h123, 32'h3132330A, 4);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rx_log[0].size() == 1 && rx_busy[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_second_frame", ok, 1'b1);
        bcd_a   = 12'h999;
        part[0] = 1'b1;
        tick();
        part[0] = 1'b0;
        finish_msg(0, 4);

        // Reset in the middle of the start bit of the second character.
        start_msg(0, 12'h123, 32'h3132330A, 4);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rx_log[0].size() == 1 && rx_busy[0] && rx_cnt[0] == BIT/2) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_reset_point", ok, 1'b1);
        check("line_low_before_reset", ser[0], 1'b0);
        #2 reset = 1'b1;
        #1;
        check("saida_async_reset", ser[0], 1'b1);
        check("ocupado_async_reset", ocup[0], 1'b0);
        exp_q[0].delete();
        repeat (3) tick();
        reset = 1'b0;
        repeat (200) tick();
        check("no_pronto_after_abort", pronto_cnt[0] - p0_cnt[0], 0);
        check("estado_after_abort", dbe[0], OCIOSO);

        start_msg(0, 12'h005, 32'h0000350A, 2);
        finish_msg(0, 2);

        start_msg(2, 12'h009, 32'h00000039, 1);
        finish_msg(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
